// File: rtl/noc_pkg.sv
// Shared fabric types: packet layout, opcodes, node IDs and arbiter state encoding.
package noc_pkg;

    typedef enum logic [1:0] {
        NOC_RD  = 2'd0,
        NOC_WR  = 2'd1,
        NOC_RSP = 2'd2
    } noc_op_e;

    typedef struct packed {
        logic [3:0]   src;
        logic [3:0]   dst;
        noc_op_e      op;
        logic [31:0]  addr;
        logic [127:0] data;
    } noc_pkt_t;

    localparam logic [3:0] NODE_CORE = 4'h1;
    localparam logic [3:0] NODE_GPIO = 4'h2;
    localparam logic [3:0] NODE_MEM  = 4'h3;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock request buffer with full/empty flags; DEPTH must be a power of two.
module noc_sync_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [7:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     rdata,
    output logic full,
    output logic empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    T               mem_q [DEPTH];
    T               mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    // Next pointer/occupancy/storage; pointers wrap naturally at a power-of-two depth.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset empties the buffer without touching storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty so it carries no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/noc_mem_arbiter.sv
// Two-port round-robin request arbiter toward memory_interface, plus ID-steered response return.
module noc_mem_arbiter
    import noc_pkg::*;
#(
    parameter int         FIFO_DEPTH = 2,
    parameter logic [3:0] PORT0_ID   = 4'h1,
    parameter logic [3:0] PORT1_ID   = 4'h2
) (
    input  logic       fclk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  noc_pkt_t   req0_pkt,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  noc_pkt_t   req1_pkt,
    output logic       mem_req_valid,
    input  logic       mem_req_ready,
    output noc_pkt_t   mem_req_pkt,
    input  logic       mem_rsp_valid,
    output logic       mem_rsp_ready,
    input  noc_pkt_t   mem_rsp_pkt,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output noc_pkt_t   rsp0_pkt,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output noc_pkt_t   rsp1_pkt,
    output logic [7:0] drop_count
);

    arb_state_e state_q, state_d;
    noc_pkt_t   out_pkt_q, out_pkt_d;
    logic       rr_q, rr_d;             // 1: port 1 has priority on a tie
    logic [7:0] drop_count_q, drop_count_d;

    noc_pkt_t   head0, head1;
    logic       full0, full1, empty0, empty1;
    logic       pop0, pop1, grant1, can_load;
    logic       hit0, hit1, drop;

    assign req0_ready = !full0;
    assign req1_ready = !full1;

    noc_sync_fifo #(.DEPTH(FIFO_DEPTH), .T(noc_pkt_t)) u_fifo0 (
        .clk   (fclk),
        .rst   (rst),
        .push  (req0_valid),
        .wdata (req0_pkt),
        .pop   (pop0),
        .rdata (head0),
        .full  (full0),
        .empty (empty0)
    );

    noc_sync_fifo #(.DEPTH(FIFO_DEPTH), .T(noc_pkt_t)) u_fifo1 (
        .clk   (fclk),
        .rst   (rst),
        .push  (req1_valid),
        .wdata (req1_pkt),
        .pop   (pop1),
        .rdata (head1),
        .full  (full1),
        .empty (empty1)
    );

    assign mem_req_valid = (state_q == ARB_HOLD);
    assign mem_req_pkt   = out_pkt_q;

    // Output stage: load a winner when idle or on the handshake cycle so back-to-back grants cost no bubble.
    always_comb begin
        state_d   = state_q;
        out_pkt_d = out_pkt_q;
        rr_d      = rr_q;
        pop0      = 1'b0;
        pop1      = 1'b0;
        grant1    = 1'b0;
        can_load  = (state_q == ARB_IDLE) || mem_req_ready;
        if (can_load) begin
            if (!empty0 || !empty1) begin
                if (empty0)      grant1 = 1'b1;
                else if (empty1) grant1 = 1'b0;
                else             grant1 = rr_q;
                pop0      = !grant1;
                pop1      = grant1;
                out_pkt_d = grant1 ? head1 : head0;
                rr_d      = !grant1;
                state_d   = ARB_HOLD;
            end else begin
                state_d = ARB_IDLE;
            end
        end
    end

    // Response steering is purely combinational and independent of request state.
    always_comb begin
        hit0          = (mem_rsp_pkt.dst == PORT0_ID);
        hit1          = (mem_rsp_pkt.dst == PORT1_ID) && !hit0;
        rsp0_valid    = mem_rsp_valid && hit0;
        rsp1_valid    = mem_rsp_valid && hit1;
        rsp0_pkt      = mem_rsp_pkt;
        rsp1_pkt      = mem_rsp_pkt;
        mem_rsp_ready = hit0 ? rsp0_ready : (hit1 ? rsp1_ready : 1'b1);
        drop          = mem_rsp_valid && !hit0 && !hit1;
        drop_count_d  = drop_count_q;
        if (drop && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    assign drop_count = drop_count_q;

    // Arbiter and drop-counter registers.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            out_pkt_q    <= '0;
            rr_q         <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            out_pkt_q    <= out_pkt_d;
            rr_q         <= rr_d;
            drop_count_q <= drop_count_d;
        end
    end

endmodule
